// File: rtl/cc_reg_write_decoder_if.sv
// Write-request bus between the datapath and the register write decoder:
// request handshake in, one-hot load vector, data and status out.
interface cc_reg_write_decoder_if #(
    parameter int DATAWIDTH_BUS         = 32,
    parameter int DATAWIDTH_DECODER_OUT = 38,
    parameter int DATAWIDTH_ADDR        = 6
);
    logic                             CC_REG_WRITE_DECODER_REQ_VALID;
    logic [DATAWIDTH_ADDR-1:0]        CC_REG_WRITE_DECODER_REQ_ADDR;
    logic [DATAWIDTH_BUS-1:0]         CC_REG_WRITE_DECODER_REQ_DATA;
    logic                             CC_REG_WRITE_DECODER_HOLD;
    logic                             CC_REG_WRITE_DECODER_REQ_READY;
    logic [DATAWIDTH_DECODER_OUT-1:0] CC_REG_WRITE_DECODER_LOAD_OUT;
    logic [DATAWIDTH_BUS-1:0]         CC_REG_WRITE_DECODER_DATA_OUT;
    logic                             CC_REG_WRITE_DECODER_ERR_OUT;
    logic [1:0]                       CC_REG_WRITE_DECODER_COUNT_OUT;

    modport master (
        output CC_REG_WRITE_DECODER_REQ_VALID,
        output CC_REG_WRITE_DECODER_REQ_ADDR,
        output CC_REG_WRITE_DECODER_REQ_DATA,
        output CC_REG_WRITE_DECODER_HOLD,
        input  CC_REG_WRITE_DECODER_REQ_READY,
        input  CC_REG_WRITE_DECODER_LOAD_OUT,
        input  CC_REG_WRITE_DECODER_DATA_OUT,
        input  CC_REG_WRITE_DECODER_ERR_OUT,
        input  CC_REG_WRITE_DECODER_COUNT_OUT
    );

    modport slave (
        input  CC_REG_WRITE_DECODER_REQ_VALID,
        input  CC_REG_WRITE_DECODER_REQ_ADDR,
        input  CC_REG_WRITE_DECODER_REQ_DATA,
        input  CC_REG_WRITE_DECODER_HOLD,
        output CC_REG_WRITE_DECODER_REQ_READY,
        output CC_REG_WRITE_DECODER_LOAD_OUT,
        output CC_REG_WRITE_DECODER_DATA_OUT,
        output CC_REG_WRITE_DECODER_ERR_OUT,
        output CC_REG_WRITE_DECODER_COUNT_OUT
    );
endinterface

// File: rtl/cc_reg_write_decoder.sv
// Register-bank write decoder: 2-entry request FIFO feeding a registered
// one-hot load-enable vector and data bus for the register cells R0..R37.
module cc_reg_write_decoder #(
    parameter int DATAWIDTH_BUS         = 32,
    parameter int DATAWIDTH_DECODER_OUT = 38,
    parameter int DATAWIDTH_ADDR        = 6,
    parameter bit ZERO_REG_PROTECT      = 1'b1
) (
    input  logic                  CC_REG_WRITE_DECODER_CLOCK_50,
    input  logic                  CC_REG_WRITE_DECODER_RESET_InHigh,
    cc_reg_write_decoder_if.slave wr_bus
);
    localparam logic [DATAWIDTH_DECODER_OUT-1:0] LOAD_ONE = DATAWIDTH_DECODER_OUT'(1);

    logic [DATAWIDTH_ADDR-1:0]        fifo_addr_q [2];
    logic [DATAWIDTH_ADDR-1:0]        fifo_addr_d [2];
    logic [DATAWIDTH_BUS-1:0]         fifo_data_q [2];
    logic [DATAWIDTH_BUS-1:0]         fifo_data_d [2];
    logic                             wr_ptr_q, wr_ptr_d;
    logic                             rd_ptr_q, rd_ptr_d;
    logic [1:0]                       count_q, count_d;
    logic [DATAWIDTH_DECODER_OUT-1:0] load_q, load_d;
    logic [DATAWIDTH_BUS-1:0]         data_q, data_d;
    logic                             err_q, err_d;

    logic                             ready_s;
    logic                             push_s;
    logic                             pop_s;
    logic [DATAWIDTH_ADDR-1:0]        head_addr_s;
    logic [DATAWIDTH_BUS-1:0]         head_data_s;

    // FIFO bookkeeping and issue decode; ready looks only at registered occupancy
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        load_d      = '0;
        err_d       = 1'b0;
        data_d      = data_q;

        ready_s     = (count_q < 2'd2) && !CC_REG_WRITE_DECODER_RESET_InHigh;
        push_s      = wr_bus.CC_REG_WRITE_DECODER_REQ_VALID && ready_s;
        pop_s       = (count_q != 2'd0) && !wr_bus.CC_REG_WRITE_DECODER_HOLD;
        head_addr_s = fifo_addr_q[rd_ptr_q];
        head_data_s = fifo_data_q[rd_ptr_q];

        if (push_s) begin
            fifo_addr_d[wr_ptr_q] = wr_bus.CC_REG_WRITE_DECODER_REQ_ADDR;
            fifo_data_d[wr_ptr_q] = wr_bus.CC_REG_WRITE_DECODER_REQ_DATA;
            wr_ptr_d              = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Dropped entries (protected R0, out-of-range) still leave the FIFO but never load
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
            if (32'(head_addr_s) >= DATAWIDTH_DECODER_OUT) begin
                err_d = 1'b1;
            end else if (ZERO_REG_PROTECT && (head_addr_s == '0)) begin
                err_d = 1'b0;
            end else begin
                load_d = LOAD_ONE << head_addr_s;
                data_d = head_data_s;
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State and output registers with synchronous flush
    always_ff @(posedge CC_REG_WRITE_DECODER_CLOCK_50) begin
        if (CC_REG_WRITE_DECODER_RESET_InHigh) begin
            fifo_addr_q[0] <= '0;
            fifo_addr_q[1] <= '0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
            load_q         <= '0;
            data_q         <= '0;
            err_q          <= 1'b0;
        end else begin
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            load_q      <= load_d;
            data_q      <= data_d;
            err_q       <= err_d;
        end
    end

    assign wr_bus.CC_REG_WRITE_DECODER_REQ_READY = ready_s;
    assign wr_bus.CC_REG_WRITE_DECODER_LOAD_OUT  = load_q;
    assign wr_bus.CC_REG_WRITE_DECODER_DATA_OUT  = data_q;
    assign wr_bus.CC_REG_WRITE_DECODER_ERR_OUT   = err_q;
    assign wr_bus.CC_REG_WRITE_DECODER_COUNT_OUT = count_q;
endmodule

// File: tb/tb_cc_reg_write_decoder.sv
// Bench for cc_reg_write_decoder: directed vector table plus randomized traffic
// checked against a queue-based reference model.
module tb_cc_reg_write_decoder;
    localparam int DW  = 32;
    localparam int DEC = 38;
    localparam int AW  = 6;
    localparam bit PROTECT = 1'b1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cc_reg_write_decoder_if #(.DATAWIDTH_BUS(DW), .DATAWIDTH_DECODER_OUT(DEC), .DATAWIDTH_ADDR(AW)) bus ();

    cc_reg_write_decoder #(
        .DATAWIDTH_BUS(DW), .DATAWIDTH_DECODER_OUT(DEC),
        .DATAWIDTH_ADDR(AW), .ZERO_REG_PROTECT(PROTECT)
    ) dut (
        .CC_REG_WRITE_DECODER_CLOCK_50(clk),
        .CC_REG_WRITE_DECODER_RESET_InHigh(rst),
        .wr_bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        logic           rst;
        logic           valid;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic           hold;
        logic [DEC-1:0] exp_load;
        logic           exp_err;
        logic [1:0]     exp_count;
        logic           exp_ready;
        logic           chk_data;
        logic [DW-1:0]  exp_data;
    } vec_t;

    ent_t           mq[$];
    logic [DEC-1:0] m_load;
    logic           m_err;
    logic [DW-1:0]  m_data;
    logic           m_data_known;
    vec_t           tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one clock edge worth of behaviour
    task automatic model_edge(input logic r, input logic v, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic h);
        ent_t e;
        bit   room;
        if (r) begin
            mq.delete();
            m_load = '0;
            m_err = 1'b0;
            m_data = '0;
            m_data_known = 1'b1;
        end else begin
            room = (mq.size() < 2);
            m_load = '0;
            m_err = 1'b0;
            if (mq.size() > 0 && !h) begin
                e = mq.pop_front();
                if (int'(e.a) >= DEC) begin
                    m_err = 1'b1;
                    m_data_known = 1'b0;
                end else if (PROTECT && e.a == 0) begin
                    m_data_known = 1'b0;
                end else begin
                    m_load[e.a] = 1'b1;
                    m_data = e.d;
                    m_data_known = 1'b1;
                end
            end
            if (v && room) begin
                e.a = a;
                e.d = d;
                mq.push_back(e);
            end
        end
    endtask

    task automatic do_cycle(input logic r, input logic v, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic h);
        rst = r;
        bus.CC_REG_WRITE_DECODER_REQ_VALID = v;
        bus.CC_REG_WRITE_DECODER_REQ_ADDR  = a;
        bus.CC_REG_WRITE_DECODER_REQ_DATA  = d;
        bus.CC_REG_WRITE_DECODER_HOLD      = h;
        @(posedge clk);
        model_edge(r, v, a, d, h);
        #1;
        check("model_load", 64'(bus.CC_REG_WRITE_DECODER_LOAD_OUT), 64'(m_load));
        check("model_err", 64'(bus.CC_REG_WRITE_DECODER_ERR_OUT), 64'(m_err));
        check("model_count", 64'(bus.CC_REG_WRITE_DECODER_COUNT_OUT), 64'(mq.size()));
        check("model_ready", 64'(bus.CC_REG_WRITE_DECODER_REQ_READY), 64'((mq.size() < 2) && !r));
        check("load_onehot0", 64'($onehot0(bus.CC_REG_WRITE_DECODER_LOAD_OUT)), 64'(1));
        if (m_data_known) begin
            check("model_data", 64'(bus.CC_REG_WRITE_DECODER_DATA_OUT), 64'(m_data));
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic h, input logic [DEC-1:0] el,
                                input logic ee, input logic [1:0] ec, input logic er,
                                input logic cd, input logic [DW-1:0] ed);
        vec_t t;
        t.rst = r; t.valid = v; t.addr = a; t.data = d; t.hold = h;
        t.exp_load = el; t.exp_err = ee; t.exp_count = ec; t.exp_ready = er;
        t.chk_data = cd; t.exp_data = ed;
        return t;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        m_load = '0; m_err = 1'b0; m_data = '0; m_data_known = 1'b0;
        rst = 1'b1;
        bus.CC_REG_WRITE_DECODER_REQ_VALID = 1'b0;
        bus.CC_REG_WRITE_DECODER_REQ_ADDR  = '0;
        bus.CC_REG_WRITE_DECODER_REQ_DATA  = '0;
        bus.CC_REG_WRITE_DECODER_HOLD      = 1'b0;

        //          rst   vld   addr    data           hold  exp_load        err   cnt    rdy   chkd  exp_data
        tbl.push_back(mk(1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 38'h0,          1'b0, 2'd0, 1'b0, 1'b1, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 6'd5,  32'hDEADBEEF, 1'b0, 38'h0,          1'b0, 2'd1, 1'b1, 1'b1, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 38'h20,         1'b0, 2'd0, 1'b1, 1'b1, 32'hDEADBEEF));
        tbl.push_back(mk(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 38'h0,          1'b0, 2'd0, 1'b1, 1'b1, 32'hDEADBEEF));
        tbl.push_back(mk(1'b0, 1'b1, 6'd1,  32'h11,       1'b1, 38'h0,          1'b0, 2'd1, 1'b1, 1'b1, 32'hDEADBEEF));
        tbl.push_back(mk(1'b0, 1'b1, 6'd2,  32'h22,       1'b1, 38'h0,          1'b0, 2'd2, 1'b0, 1'b1, 32'hDEADBEEF));
        tbl.push_back(mk(1'b0, 1'b1, 6'd3,  32'h33,       1'b1, 38'h0,          1'b0, 2'd2, 1'b0, 1'b1, 32'hDEADBEEF));
        tbl.push_back(mk(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 38'h2,          1'b0, 2'd1, 1'b1, 1'b1, 32'h11));
        tbl.push_back(mk(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 38'h4,          1'b0, 2'd0, 1'b1, 1'b1, 32'h22));
        tbl.push_back(mk(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 38'h0,          1'b0, 2'd0, 1'b1, 1'b1, 32'h22));
        tbl.push_back(mk(1'b0, 1'b1, 6'd37, 32'hA,        1'b0, 38'h0,          1'b0, 2'd1, 1'b1, 1'b1, 32'h22));
        tbl.push_back(mk(1'b0, 1'b1, 6'd36, 32'hB,        1'b0, 38'h20_0000_0000, 1'b0, 2'd1, 1'b1, 1'b1, 32'hA));
        tbl.push_back(mk(1'b0, 1'b1, 6'd10, 32'hC,        1'b0, 38'h10_0000_0000, 1'b0, 2'd1, 1'b1, 1'b1, 32'hB));
        tbl.push_back(mk(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 38'h400,        1'b0, 2'd0, 1'b1, 1'b1, 32'hC));
        tbl.push_back(mk(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 38'h0,          1'b0, 2'd0, 1'b1, 1'b1, 32'hC));
        tbl.push_back(mk(1'b0, 1'b1, 6'd0,  32'h1,        1'b0, 38'h0,          1'b0, 2'd1, 1'b1, 1'b1, 32'hC));
        tbl.push_back(mk(1'b0, 1'b1, 6'd38, 32'h2,        1'b0, 38'h0,          1'b0, 2'd1, 1'b1, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 6'd63, 32'h3,        1'b0, 38'h0,          1'b1, 2'd1, 1'b1, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 6'd37, 32'h4,        1'b0, 38'h0,          1'b1, 2'd1, 1'b1, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 38'h20_0000_0000, 1'b0, 2'd0, 1'b1, 1'b1, 32'h4));
        tbl.push_back(mk(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 38'h0,          1'b0, 2'd0, 1'b1, 1'b1, 32'h4));
        tbl.push_back(mk(1'b0, 1'b1, 6'd7,  32'h77,       1'b1, 38'h0,          1'b0, 2'd1, 1'b1, 1'b1, 32'h4));
        tbl.push_back(mk(1'b0, 1'b1, 6'd8,  32'h88,       1'b1, 38'h0,          1'b0, 2'd2, 1'b0, 1'b1, 32'h4));
        tbl.push_back(mk(1'b1, 1'b0, 6'd0,  32'h0,        1'b1, 38'h0,          1'b0, 2'd0, 1'b0, 1'b1, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 38'h0,          1'b0, 2'd0, 1'b1, 1'b1, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 38'h0,          1'b0, 2'd0, 1'b1, 1'b1, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 6'd20, 32'h14,       1'b0, 38'h0,          1'b0, 2'd1, 1'b1, 1'b1, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 6'd21, 32'h15,       1'b0, 38'h10_0000,    1'b0, 2'd1, 1'b1, 1'b1, 32'h14));
        tbl.push_back(mk(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 38'h20_0000,    1'b0, 2'd0, 1'b1, 1'b1, 32'h15));

        foreach (tbl[i]) begin
            do_cycle(tbl[i].rst, tbl[i].valid, tbl[i].addr, tbl[i].data, tbl[i].hold);
            check($sformatf("vec%0d_load", i), 64'(bus.CC_REG_WRITE_DECODER_LOAD_OUT), 64'(tbl[i].exp_load));
            check($sformatf("vec%0d_err", i), 64'(bus.CC_REG_WRITE_DECODER_ERR_OUT), 64'(tbl[i].exp_err));
            check($sformatf("vec%0d_count", i), 64'(bus.CC_REG_WRITE_DECODER_COUNT_OUT), 64'(tbl[i].exp_count));
            check($sformatf("vec%0d_ready", i), 64'(bus.CC_REG_WRITE_DECODER_REQ_READY), 64'(tbl[i].exp_ready));
            if (tbl[i].chk_data) begin
                check($sformatf("vec%0d_data", i), 64'(bus.CC_REG_WRITE_DECODER_DATA_OUT), 64'(tbl[i].exp_data));
            end
        end

        // Long stall with continuous requests, then release
        for (int i = 0; i < 12; i++) begin
            do_cycle(1'b0, 1'b1, AW'(i + 1), 32'(32'h100 + i), 1'b1);
        end
        check("stall_ready_low", 64'(bus.CC_REG_WRITE_DECODER_REQ_READY), 64'(0));
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 1'b0, 6'd0, 32'h0, 1'b0);
        end
        check("drained_count", 64'(bus.CC_REG_WRITE_DECODER_COUNT_OUT), 64'(0));

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            do_cycle(($urandom_range(0, 99) == 0),
                     ($urandom_range(0, 9) < 7),
                     AW'($urandom_range(0, 63)),
                     32'($urandom),
                     ($urandom_range(0, 9) < 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cc_reg_write_decoder.md
Name: cc_reg_write_decoder

Overview:
- Write-side counterpart of the register-bank read multiplexer in the uDataPath.
- Accepts write-back requests from the datapath bus with a binary destination address. Buffers them in a 2-entry FIFO.
- Issues each request as a one-cycle, one-hot load-enable vector plus data to the 38 register cells (R0..R37).
- Stalls when the datapath asserts hold.

Parameters:
- DATAWIDTH_BUS, 32, width of the data bus and of each register.
- DATAWIDTH_DECODER_OUT, 38, number of registers, which is also the one-hot load vector width.
- DATAWIDTH_ADDR, 6, binary destination address width.
- ZERO_REG_PROTECT, 1, when 1 a write to address 0 is discarded silently.

Ports:
- CC_REG_WRITE_DECODER_CLOCK_50  input  1  system clock; all logic is on the rising edge.
- CC_REG_WRITE_DECODER_RESET_InHigh  input  1  reset, synchronous, active-high.
- CC_REG_WRITE_DECODER_REQ_VALID  input  1  a write request is present.
- CC_REG_WRITE_DECODER_REQ_ADDR  input  DATAWIDTH_ADDR  binary destination register index.
- CC_REG_WRITE_DECODER_REQ_DATA  input  DATAWIDTH_BUS  write data.
- CC_REG_WRITE_DECODER_HOLD  input  1  datapath stall; blocks issue.
- CC_REG_WRITE_DECODER_REQ_READY  output  1  the block can accept a request this cycle.
- CC_REG_WRITE_DECODER_LOAD_OUT  output  DATAWIDTH_DECODER_OUT  one-hot load enable; bit k loads Rk.
- CC_REG_WRITE_DECODER_DATA_OUT  output  DATAWIDTH_BUS  data presented to the register cells.
- CC_REG_WRITE_DECODER_ERR_OUT  output  1  one-cycle pulse when an out-of-range address is dropped.
- CC_REG_WRITE_DECODER_COUNT_OUT  output  2  FIFO occupancy, 0..2.

Behaviour:
- Reset (synchronous, active-high): FIFO flushed, count=0, LOAD_OUT=0, DATA_OUT=0, ERR_OUT=0.
- REQ_READY=0 while reset is asserted. It reads 1 in the first cycle after reset deasserts.
- A reset asserted mid-operation discards all queued and pending writes; no LOAD_OUT pulse follows.
- REQ_READY = (count<2) && !reset. It is derived from the registered count only and does not depend on issue in the same cycle.
- When full, a simultaneous pop does not open a slot until the next cycle.
- Push: on a rising edge with REQ_VALID && REQ_READY, {ADDR, DATA} is written at the FIFO tail.
- Pop/issue: on a rising edge with count>0 && !HOLD, the head is removed.
  - Next cycle, LOAD_OUT = 1<<ADDR and DATA_OUT = head data.
  - LOAD_OUT is high for exactly one cycle per issued write.
- Issue cases by address:
  - ADDR=0 with ZERO_REG_PROTECT=1: entry popped, LOAD_OUT=0, ERR_OUT=0.
  - ADDR=0 with ZERO_REG_PROTECT=0: normal issue, LOAD_OUT bit 0 set.
  - ADDR>=DATAWIDTH_DECODER_OUT (38..63): entry popped, LOAD_OUT=0, ERR_OUT=1 for one cycle.
- Cycles with no issue (empty or HOLD): LOAD_OUT=0 and ERR_OUT=0. DATA_OUT holds its last value.
- Push and pop on the same edge: count is unchanged and ordering is preserved.
- Latency: a request pushed at edge N into an empty FIFO with HOLD=0 produces LOAD_OUT visible after edge N+1 (2-edge latency). Throughput is 1 write per cycle.
- HOLD: the FIFO still accepts requests until full. Issue resumes on the first edge with HOLD=0.
- Ordering: strict FIFO; writes reach the registers in request order.
- Invariants:
  - LOAD_OUT is never multi-hot.
  - count never exceeds 2.
  - No write is ever lost or duplicated except for addr-0 protect, out-of-range addresses and reset.

Test Plan:
- Single write: reset, then VALID=1, ADDR=5, DATA=0xDEADBEEF for 1 cycle, HOLD=0 -> two edges later LOAD_OUT=38'h20 and DATA_OUT=0xDEADBEEF for exactly 1 cycle; COUNT_OUT returns to 0.
- HOLD/full: HOLD=1, push ADDR=1/0x11, 2/0x22 -> COUNT_OUT=2 and READY=0; a third request ADDR=3 is not accepted. Release HOLD -> LOAD_OUT=0x2 with 0x11, then 0x4 with 0x22 on consecutive cycles; READY=1 again.
- Back-to-back: HOLD=0, push ADDR=37/0xA, 36/0xB, 10/0xC on three consecutive cycles -> LOAD_OUT bit37, then bit36, then bit10 on consecutive cycles with matching data; COUNT_OUT never exceeds 1.
- Address boundaries: ADDR=0 (protect on) -> no LOAD, no ERR. ADDR=38 and ADDR=63 -> LOAD_OUT=0 and ERR_OUT pulses once each. ADDR=37 -> bit37 set.
- Reset mid-operation: HOLD=1, queue 2 writes, assert RESET for 1 cycle, deassert HOLD -> no LOAD_OUT pulse at all; COUNT_OUT=0; READY=0 during reset and 1 after.
- Simultaneous push/pop at count=1: COUNT_OUT stays 1 and both writes are issued in order on consecutive cycles.
